serial_adder_unit: RTL and testbench

Parametrised, sequential successor to the two-input half-adder cell (AND carry, XOR sum). It adds two WIDTH-bit operands digit-serially, processing DIGIT bits per clock through a chained half/full-adder slice with a registered carry. It also offers a carry-less XOR mode. Operands enter and results leave through valid/ready handshakes, so the block sits between the operand source and the result consumer in the datapath.

---
 rtl/serial_adder_unit.sv | 118 +++++++++++
 tb/tb_serial_adder_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_unit.sv
// Digit-serial adder: adds two WIDTH-bit operands DIGIT bits per clock through a
// rippled half/full-adder slice with a registered carry; optional carry-less XOR mode.
module serial_adder_unit #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             carry_reg;
    logic             mode_reg;
    logic [WIDTH-1:0] a_reg, b_reg, res_reg, res_next;
    logic [WIDTH-1:0] out_sum_reg;
    logic             out_carry_reg;
    logic [DIGIT:0]   chain;
    logic [DIGIT-1:0] digit_sum;
    logic             last_step;

    assign last_step = (cnt_reg == CNT_W'(STEPS - 1));
    assign chain[0]  = carry_reg;

    // One adder cell per bit of the digit; XOR mode kills every carry.
    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
            logic a_bit, b_bit, p_bit;
            assign a_bit         = a_reg[gi];
            assign b_bit         = b_reg[gi];
            assign p_bit         = a_bit ^ b_bit;
            assign digit_sum[gi] = p_bit ^ chain[gi];
            assign chain[gi+1]   = mode_reg ? 1'b0 : ((a_bit & b_bit) | (chain[gi] & p_bit));
        end
    endgenerate

    // Sum digits enter at the MSB end so the last digit lands in place.
    generate
        if (WIDTH > DIGIT) begin : g_shift
            assign res_next = {digit_sum, res_reg[WIDTH-1:DIGIT]};
        end else begin : g_single
            assign res_next = digit_sum;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg       <= '0;
            carry_reg     <= 1'b0;
            mode_reg      <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            res_reg       <= '0;
            out_sum_reg   <= '0;
            out_carry_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= in_a;
                        b_reg     <= in_b;
                        mode_reg  <= in_mode;
                        carry_reg <= 1'b0;
                        cnt_reg   <= '0;
                    end
                end
                RUN: begin
                    a_reg     <= a_reg >> DIGIT;
                    b_reg     <= b_reg >> DIGIT;
                    res_reg   <= res_next;
                    carry_reg <= chain[DIGIT];
                    cnt_reg   <= cnt_reg + CNT_W'(1);
                    if (last_step) begin
                        out_sum_reg   <= res_next;
                        out_carry_reg <= chain[DIGIT];
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign out_sum   = out_sum_reg;
    assign out_carry = out_carry_reg;
endmodule

// File: tb/tb_serial_adder_unit.sv
// Scoreboard bench for serial_adder_unit: three configurations (8/1, 8/4, 4/4)
// driven with directed vectors; a monitor checks result, carry and latency.
module tb_serial_adder_unit;
    typedef struct {
        int         dut;
        logic [7:0] sum;
        logic       carry;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] in_valid;
    logic [7:0] in_a, in_b;
    logic       in_mode;
    logic       out_ready;
    logic [2:0] in_rdy, out_vld, cout, prev_vld;
    logic [7:0] sum0, sum1;
    logic [3:0] sum2;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder_unit #(.WIDTH(8), .DIGIT(1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_rdy[0]),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_vld[0]),
        .out_ready(out_ready), .out_sum(sum0), .out_carry(cout[0]));

    serial_adder_unit #(.WIDTH(8), .DIGIT(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_rdy[1]),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_vld[1]),
        .out_ready(out_ready), .out_sum(sum1), .out_carry(cout[1]));

    serial_adder_unit #(.WIDTH(4), .DIGIT(4)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_rdy[2]),
        .in_a(in_a[3:0]), .in_b(in_b[3:0]), .in_mode(in_mode), .out_valid(out_vld[2]),
        .out_ready(out_ready), .out_sum(sum2), .out_carry(cout[2]));

    function automatic int steps_of(input int d);
        return (d == 0) ? 8 : ((d == 1) ? 2 : 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic mon(input int d, input logic [7:0] s, input logic c);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: dut%0d sum=%0h carry=%0b, required no output", d, s, c);
        end else begin
            e = q.pop_front();
            $display("txn dut%0d sum=%02h carry=%0b cycle=%0d", d, s, c, cyc);
            chk($sformatf("dut%0d_id", d), d, e.dut);
            chk($sformatf("dut%0d_sum", d), {24'h0, s}, {24'h0, e.sum});
            chk($sformatf("dut%0d_carry", d), {31'h0, c}, {31'h0, e.carry});
            chk($sformatf("dut%0d_latency", d), cyc, e.cyc);
        end
    endtask

    // Monitor: compare on every rising edge of out_valid.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst && out_vld[d] && !prev_vld[d])
                mon(d, (d == 0) ? sum0 : ((d == 1) ? sum1 : {4'h0, sum2}), cout[d]);
        end
        prev_vld <= rst ? 3'b000 : out_vld;
    end

    task automatic issue(input int d, input logic [7:0] a, input logic [7:0] b, input logic m,
                         input logic [7:0] es, input logic ec, input bit push);
        int   n;
        exp_t e;
        @(negedge clk);
        in_a = a;
        in_b = b;
        in_mode = m;
        in_valid[d] = 1'b1;
        n = 0;
        while (!in_rdy[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_rdy[d]) begin
            errors++;
            $display("FAIL accept_timeout: dut%0d in_ready=0, required 1", d);
            in_valid[d] = 1'b0;
            return;
        end
        if (push) begin
            e.dut = d;
            e.sum = es;
            e.carry = ec;
            e.cyc = cyc + 1 + steps_of(d);
            q.push_back(e);
        end
        @(negedge clk);
        in_valid[d] = 1'b0;
        in_a = ~a;
        in_b = ~b;
        in_mode = ~m;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results pending, required 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        in_valid = 3'b000;
        in_a = 8'h00;
        in_b = 8'h00;
        in_mode = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", {29'h0, out_vld}, 32'h0);
        chk("reset_in_ready", {29'h0, in_rdy}, 32'h7);
        chk("reset_sum0", {24'h0, sum0}, 32'h0);
        chk("reset_carry", {29'h0, cout}, 32'h0);
        rst = 1'b0;

        // Add and XOR on the bit-serial instance.
        issue(0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1); drain();
        issue(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1); drain();
        issue(0, 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1); drain();
        issue(0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1); drain();
        issue(0, 8'hFF, 8'h01, 1'b1, 8'hFE, 1'b0, 1); drain();
        issue(0, 8'hA5, 8'h5A, 1'b1, 8'hFF, 1'b0, 1); drain();

        // Reset three clocks into an operation aborts it.
        issue(0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", {31'h0, out_vld[0]}, 32'h0);
        chk("abort_sum0", {24'h0, sum0}, 32'h0);
        chk("abort_carry", {31'h0, cout[0]}, 32'h0);
        chk("abort_in_ready", {31'h0, in_rdy[0]}, 32'h1);
        issue(0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1); drain();

        // Backpressure: result holds and a new request is ignored.
        out_ready = 1'b0;
        issue(0, 8'h80, 8'h81, 1'b0, 8'h01, 1'b1, 1);
        n = 0;
        while (!out_vld[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_rise", {31'h0, out_vld[0]}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", {31'h0, out_vld[0]}, 32'h1);
            chk("bp_sum0", {24'h0, sum0}, 32'h01);
            chk("bp_carry", {31'h0, cout[0]}, 32'h1);
            chk("bp_in_ready", {31'h0, in_rdy[0]}, 32'h0);
            if (i == 1) begin
                in_valid[0] = 1'b1;
                in_a = 8'h11;
                in_b = 8'h22;
            end
            if (i == 3) in_valid[0] = 1'b0;
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", {31'h0, out_vld[0]}, 32'h0);
        chk("bp_release_ready", {31'h0, in_rdy[0]}, 32'h1);
        drain();
        repeat (12) @(negedge clk);

        // Four-bit digits, and a single-step configuration.
        issue(1, 8'h9F, 8'h71, 1'b0, 8'h10, 1'b1, 1); drain();
        issue(1, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1); drain();
        issue(1, 8'h9F, 8'h71, 1'b1, 8'hEE, 1'b0, 1); drain();
        issue(2, 8'h0F, 8'h01, 1'b0, 8'h00, 1'b1, 1); drain();
        issue(2, 8'h07, 8'h08, 1'b0, 8'h0F, 1'b0, 1); drain();
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
